// File: rtl/fps_uart_host.sv
// fps_uart_host: FPGA-side register master for the FPS digital_core UART link (posi out, piso in).
// Optional build macro FPS_HOST_WRITE_VERIFY_EN adds an automatic readback check after every write.
module fps_uart_host #(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wrb,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       posi,
  input  logic       piso,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic [7:0] unsol_cnt
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_WAIT_RSP, S_DONE} state_t;
  state_t state, state_n;

  logic [19:0]   tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [4:0]    tx_bit;
  logic          tx_last;
  logic          lat_wrb;
  logic [7:0]    lat_addr;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          accept;
`ifdef FPS_HOST_WRITE_VERIFY_EN
  logic [7:0]    lat_data;
  logic          verify_q;
`endif
  logic          s1, s2, s3;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [4:0]    rx_bit;
  logic [17:0]   rx_sh;
  logic [17:0]   rx_pkt;
  logic          rx_done;
  logic [1:0]    chk_err;

  // Full UART frame, LSB first: start, pkt[0..17], stop.
  function automatic logic [19:0] make_frame(input logic [7:0] a, input logic [7:0] d,
                                             input logic w);
    logic [16:0] p;
    p = {a, d, w};
    return {1'b1, ~^p, p, 1'b0};
  endfunction

  assign accept  = cmd_valid & cmd_ready;
  assign tx_last = (tx_cnt == CW'(CLKS_PER_BIT - 1)) && (tx_bit == 5'd19);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign posi    = (state == S_TX) ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (accept) state_n = S_TX;
      S_TX: begin
        if (tx_last) begin
`ifdef FPS_HOST_WRITE_VERIFY_EN
          state_n = (lat_wrb || verify_q) ? S_WAIT_RSP : S_TX;
`else
          state_n = lat_wrb ? S_WAIT_RSP : S_DONE;
`endif
        end
      end
      S_WAIT_RSP: if (rx_done || tmo_hit) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    chk_err = 2'd0;
    if (!(^rx_pkt))                    chk_err = 2'd1;
    else if (rx_pkt[16:9] != lat_addr) chk_err = 2'd2;
`ifdef FPS_HOST_WRITE_VERIFY_EN
    else if (verify_q && (rx_pkt[8:1] != lat_data)) chk_err = 2'd2;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      tx_sh     <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      lat_wrb   <= 1'b0;
      lat_addr  <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= '0;
      unsol_cnt <= '0;
`ifdef FPS_HOST_WRITE_VERIFY_EN
      lat_data  <= '0;
      verify_q  <= 1'b0;
`endif
    end else begin
      cmd_ready <= (state_n == S_IDLE);
      rsp_valid <= (state == S_DONE);
      tmo_cnt   <= (state == S_WAIT_RSP) ? tmo_cnt + TW'(1) : '0;
      if (accept) begin
        lat_wrb  <= cmd_wrb;
        lat_addr <= cmd_addr;
        tx_sh    <= make_frame(cmd_addr, cmd_wrb ? 8'h00 : cmd_data, cmd_wrb);
        tx_cnt   <= '0;
        tx_bit   <= '0;
`ifdef FPS_HOST_WRITE_VERIFY_EN
        lat_data <= cmd_data;
        verify_q <= 1'b0;
`endif
      end else if (state == S_TX) begin
        if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 5'd19) begin
            tx_bit <= '0;
`ifdef FPS_HOST_WRITE_VERIFY_EN
            // Write frame done: reload the shifter with the readback request, staying in TX.
            if (!lat_wrb && !verify_q) begin
              verify_q <= 1'b1;
              tx_sh    <= make_frame(lat_addr, 8'h00, 1'b1);
            end
`endif
          end else begin
            tx_bit <= tx_bit + 5'd1;
            tx_sh  <= {1'b1, tx_sh[19:1]};
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
      if (state == S_TX && state_n == S_DONE) begin
        rsp_data <= '0;
        rsp_err  <= '0;
      end else if (state == S_WAIT_RSP) begin
        if (rx_done) begin
          rsp_data <= rx_pkt[8:1];
          rsp_err  <= chk_err;
        end else if (tmo_hit) begin
          rsp_data <= '0;
          rsp_err  <= 2'd3;
        end
      end
      if (rx_done && state != S_WAIT_RSP && unsol_cnt != 8'hFF)
        unsol_cnt <= unsol_cnt + 8'd1;
    end
  end

  // Receiver: the start bit must stay low through its last sample, which rejects
  // glitches that outlast the mid-start check but are shorter than one bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_pkt  <= '0;
      rx_done <= 1'b0;
    end else begin
      s1      <= piso;
      s2      <= s1;
      s3      <= s2;
      rx_done <= 1'b0;
      if (!rx_busy) begin
        if (s3 && !s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 5'd0) begin
        if (s2 && (rx_cnt <= CW'(CLKS_PER_BIT - 2))) begin
          rx_busy <= 1'b0;
        end else if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt <= '0;
          rx_bit <= 5'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else begin
        if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          if (rx_bit == 5'd19) begin
            rx_busy <= 1'b0;
            rx_done <= s2;
            rx_pkt  <= rx_sh;
          end else begin
            rx_sh <= {s2, rx_sh[17:1]};
          end
        end
        if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 5'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end
    end
  end

endmodule
